// File: rtl/sub16_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional status flags are enabled with the SUB16_SERIAL_FLAGS_EN macro.
package sub16_serial_pkg;

   localparam int SUB_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/sub16_serial_full_adder.sv
// Library one-bit full adder cell; in[1] and in[0] are the two addend bits.
module full_adder (
   input  logic [1:0] in,
   input  logic       c_in,
   output logic       sum,
   output logic       c_out
);

   assign sum   = in[1] ^ in[0] ^ c_in;
   assign c_out = (in[1] & in[0]) | (c_in & (in[1] ^ in[0]));

endmodule

// File: rtl/sub16_serial.sv
// Bit-serial in0 - in1 using one full adder, LSB first, with start/busy/done handshake.
// Define SUB16_SERIAL_FLAGS_EN to add the registered zero and signed-overflow flags.
module sub16_serial
   import sub16_serial_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             b_out
`ifdef SUB16_SERIAL_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   // Holds the WIDTH-1 bits already produced; the final bit goes straight to out.
   logic [WIDTH-2:0] r_q;
   logic             c_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] out_q;
   logic             b_out_q;

   logic             sum_w;
   logic             carry_w;
   logic [WIDTH-1:0] res_d;

   full_adder u_fa (
      .in    ({a_q[0], ~b_q[0]}),
      .c_in  (c_q),
      .sum   (sum_w),
      .c_out (carry_w)
   );

   assign res_d = {sum_w, r_q};

`ifdef SUB16_SERIAL_FLAGS_EN
   logic a_msb_q;
   logic b_msb_q;
   logic zero_q;
   logic ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == IDLE && start) begin
         a_msb_q <= in0[WIDTH-1];
         b_msb_q <= in1[WIDTH-1];
      end else if (state_q == SHIFT && cnt_q == LAST_BIT) begin
         zero_q <= ~|res_d;
         ovf_q  <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
      end
   end

   assign zero = zero_q;
   assign ovf  = ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         b_out_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= in0;
                  b_q     <= in1;
                  c_q     <= 1'b1;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               r_q   <= res_d[WIDTH-1:1];
               c_q   <= carry_w;
               cnt_q <= cnt_q + 1'b1;
               // Results are registered on the last bit so they are valid during DONE.
               if (cnt_q == LAST_BIT) begin
                  out_q   <= res_d;
                  b_out_q <= ~carry_w;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign out   = out_q;
   assign b_out = b_out_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Directed self-checking bench for sub16_serial (WIDTH = 16).
// Flag checks are compiled in when SUB16_SERIAL_FLAGS_EN is defined.
module tb_sub16_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] in0 = '0;
   logic [15:0] in1 = '0;
   logic        busy;
   logic        done;
   logic [15:0] out;
   logic        b_out;
`ifdef SUB16_SERIAL_FLAGS_EN
   logic        zero;
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   sub16_serial #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in0   (in0),
      .in1   (in1),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .b_out (b_out)
`ifdef SUB16_SERIAL_FLAGS_EN
      ,
      .zero  (zero),
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts one operation from IDLE and waits (bounded) for done; leaves the bench at the done negedge.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        output int busy_cnt, output bit got_done);
      in0   = a;
      in1   = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_cnt = 0;
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(negedge clk);
         if (done) got_done = 1'b1;
         else if (busy) busy_cnt++;
      end
      $display("op %04h - %04h -> out=%04h b_out=%0d busy_cycles=%0d done=%0d",
               a, b, out, b_out, busy_cnt, got_done);
   endtask

   task automatic finish_op(input string tag);
      @(negedge clk);
      check({tag, "_done_low"}, done, 1'b0);
   endtask

   int bc;
   bit gd;
   int ndone;
   int cyc;
   int last;
   bit prev_done;

   initial begin
      // Power-up reset
      #2;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_out", out, 16'h0000);
      check("rst_bout", b_out, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of an operation
      in0   = 16'd5;
      in1   = 16'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1 check("midrst_busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_out", out, 16'h0000);
      check("midrst_bout", b_out, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      $display("reset mid-operation: dones after release=%0d", ndone);

      do_op(16'd9, 16'd4, bc, gd);
      check("after_rst_done", gd, 1'b1);
      check("after_rst_out", out, 16'h0005);
      finish_op("after_rst");

      // Basic subtraction with latency check
      do_op(16'h0005, 16'h0003, bc, gd);
      check("basic_done", gd, 1'b1);
      check("basic_busy_cycles", bc, 16);
      check("basic_busy_in_done", busy, 1'b0);
      check("basic_out", out, 16'h0002);
      check("basic_bout", b_out, 1'b0);
      finish_op("basic");
      check("basic_out_held", out, 16'h0002);

      // Borrow out
      do_op(16'h0000, 16'h0001, bc, gd);
      check("borrow_done", gd, 1'b1);
      check("borrow_out", out, 16'hFFFF);
      check("borrow_bout", b_out, 1'b1);
`ifdef SUB16_SERIAL_FLAGS_EN
      check("borrow_zero", zero, 1'b0);
      check("borrow_ovf", ovf, 1'b0);
`endif
      finish_op("borrow");

      // Signed overflow
      do_op(16'h8000, 16'h0001, bc, gd);
      check("ovf_done", gd, 1'b1);
      check("ovf_out", out, 16'h7FFF);
      check("ovf_bout", b_out, 1'b0);
`ifdef SUB16_SERIAL_FLAGS_EN
      check("ovf_flag", ovf, 1'b1);
      check("ovf_zero", zero, 1'b0);
`endif
      finish_op("ovf");

      // Equal operands, second start during busy must be ignored
      in0   = 16'h1234;
      in1   = 16'h1234;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      in0 = 16'hFFFF;
      @(posedge clk);
      #1 start = 1'b0;
      ndone = 0;
      bc    = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               check("equal_out", out, 16'h0000);
               check("equal_bout", b_out, 1'b0);
`ifdef SUB16_SERIAL_FLAGS_EN
               check("equal_zero", zero, 1'b1);
               check("equal_ovf", ovf, 1'b0);
`endif
            end
         end
      end
      check("equal_one_done", ndone, 1);
      $display("op 1234 - 1234 (start ignored while busy) -> out=%04h dones=%0d", out, ndone);

      // Back-to-back with start held high
      in0       = 16'h00FF;
      in1       = 16'h000F;
      start     = 1'b1;
      cyc       = 0;
      ndone     = 0;
      last      = -1;
      prev_done = 1'b0;
      for (int i = 0; i < 100 && ndone < 3; i++) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            check("b2b_out", out, 16'h00F0);
            check("b2b_done_single", prev_done, 1'b0);
            if (last >= 0) check("b2b_period", cyc - last, 18);
            $display("b2b result %0d: out=%04h at cycle %0d", ndone, out, cyc);
            last = cyc;
            ndone++;
         end
         prev_done = done;
      end
      start = 1'b0;
      check("b2b_count", ndone, 3);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
